// File: rtl/mul_repeated_add_pkg.sv
// Shared types and constants for the repeated-addition multiplier.
// Holds the controller state encoding and the default datapath width.
package mul_repeated_add_pkg;

    localparam int unsigned DefaultWidth = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadA = 3'd1,
        StLoadB = 3'd2,
        StMult  = 3'd3,
        StDone  = 3'd4
    } state_e;

endpackage

// File: rtl/mul_add_datapath.sv
// Datapath for the repeated-addition multiplier: A register, B down-counter,
// P accumulator and the B==0 detector.
module mul_add_datapath
    import mul_repeated_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ld_a_i,
    input  logic             ld_b_i,
    input  logic             ld_p_i,
    input  logic             clr_p_i,
    input  logic             dec_b_i,
    output logic             b_last_o,
    output logic [WIDTH-1:0] p_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             eqz;

    assign eqz      = (b_q == '0);
    assign b_last_o = (b_q == WIDTH'(1));
    assign p_o      = p_q;

    always_comb begin
        a_d = a_q;
        if (ld_a_i) begin
            a_d = data_i;
        end
    end

    // Decrement is gated by eqz so the counter can never wrap below zero.
    always_comb begin
        b_d = b_q;
        if (ld_b_i) begin
            b_d = data_i;
        end else if (dec_b_i && !eqz) begin
            b_d = b_q - WIDTH'(1);
        end
    end

    always_comb begin
        p_d = p_q;
        if (clr_p_i) begin
            p_d = '0;
        end else if (ld_p_i) begin
            p_d = p_q + a_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/mul_repeated_add.sv
// Sequential unsigned multiplier: loads A then B from a shared bus and adds
// A into the accumulator B times under control of a small FSM.
module mul_repeated_add
    import mul_repeated_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] product,
    output logic             done,
    output logic             busy
);

    state_e state_q, state_d;

    logic ld_a;
    logic ld_b;
    logic ld_p;
    logic clr_p;
    logic dec_b;
    logic b_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero B operand skips MULT entirely; the check uses the bus value
    // because the B register is only written on this same edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoadA;
            StLoadA: state_d = StLoadB;
            StLoadB: state_d = (data_in == '0) ? StDone : StMult;
            StMult:  if (b_last) state_d = StDone;
            StDone:  if (!start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        ld_p  = 1'b0;
        clr_p = 1'b0;
        dec_b = 1'b0;
        done  = 1'b0;
        busy  = 1'b0;
        unique case (state_q)
            StLoadA: begin
                ld_a = 1'b1;
                busy = 1'b1;
            end
            StLoadB: begin
                ld_b  = 1'b1;
                clr_p = 1'b1;
                busy  = 1'b1;
            end
            StMult: begin
                ld_p  = 1'b1;
                dec_b = 1'b1;
                busy  = 1'b1;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    mul_add_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .data_i   (data_in),
        .ld_a_i   (ld_a),
        .ld_b_i   (ld_b),
        .ld_p_i   (ld_p),
        .clr_p_i  (clr_p),
        .dec_b_i  (dec_b),
        .b_last_o (b_last),
        .p_o      (product)
    );

endmodule

// File: tb/tb_mul_repeated_add.sv
// Directed bench for mul_repeated_add: hand-computed products and cycle counts,
// zero operands, wrap-around, back-to-back operation and asynchronous reset.
module tb_mul_repeated_add;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] product;
    logic             done;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    mul_repeated_add #(
        .WIDTH(WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        #1;
        check_eq("rst_product", 32'(product), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts in IDLE at a negedge with start low; ends in DONE with start high.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_p, input bit toggle);
        int cycles;
        int exp_cycles;
        start = 1'b1;
        @(posedge clk);                      // edge 0: IDLE -> LOAD_A
        @(negedge clk);
        check_eq({tag, "_busy_la"}, 32'(busy), 32'd1);
        data_in = a;
        @(posedge clk);                      // edge 1
        @(negedge clk);
        data_in = b;
        @(posedge clk);                      // edge 2
        @(negedge clk);
        data_in = 16'hDEAD;
        cycles = 2;
        while (!done && cycles < 200) begin
            if (toggle) start = ~start;
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        exp_cycles = (b == '0) ? 2 : 2 + int'(b);
        check_eq({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
        check_eq({tag, "_product"}, 32'(product), 32'(exp_p));
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_done_held"}, 32'(done), 32'd1);
        check_eq({tag, "_product_held"}, 32'(product), 32'(exp_p));
    endtask

    task automatic drop_start(input string tag);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_idle_done"}, 32'(done), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        apply_reset();

        run_op("basic", 16'd17, 16'd5, 16'd85, 1'b0);
        drop_start("basic");
        run_op("b2b", 16'd3, 16'd4, 16'd12, 1'b0);
        drop_start("b2b");
        run_op("zero_b", 16'd9, 16'd0, 16'd0, 1'b0);
        drop_start("zero_b");
        run_op("zero_a", 16'd0, 16'd7, 16'd0, 1'b0);
        drop_start("zero_a");
        run_op("ovf_ffff", 16'hFFFF, 16'd2, 16'hFFFE, 1'b0);
        drop_start("ovf_ffff");
        run_op("ovf_8000", 16'h8000, 16'd2, 16'h0000, 1'b0);
        drop_start("ovf_8000");

        // Abort in the middle of MULT with an asynchronous reset.
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_in = 16'd100;
        @(posedge clk);
        @(negedge clk);
        data_in = 16'd50;
        repeat (4) @(posedge clk);
        #2;
        check_eq("mid_busy_before", 32'(busy), 32'd1);
        check_eq("mid_partial", 32'(product), 32'd300);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_product", 32'(product), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        run_op("after_rst", 16'd6, 16'd7, 16'd42, 1'b0);
        drop_start("after_rst");

        run_op("toggle", 16'd4, 16'd3, 16'd12, 1'b1);
        drop_start("toggle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
